// File: rtl/wdt_multi.sv
// wdt_multi: multi-channel watchdog; each channel times its KICK against a shared 1 kHz tick and drives a reset pulse.
// Define WDT_WINDOW_EN to treat kicks arriving before WINDOW_MIN ticks as faults (sets EARLY).
module wdt_multi #(
    parameter int CHANNELS   = 4,
    parameter int CNT_W      = 16,
    parameter int DELAY_TIME = 1000,
    parameter int RESET_TIME = 50,
    parameter int WINDOW_MIN = 0
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CLK_1kHz,
    input  logic [CHANNELS-1:0] KICK,
    input  logic [CHANNELS-1:0] ENABLE,
    input  logic                CLR_STICKY,
    output logic [CHANNELS-1:0] RESET,
    output logic                RESET_ANY,
    output logic [CHANNELS-1:0] STICKY,
    output logic [CHANNELS-1:0] EARLY
);

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_FIRE     = 2'd2;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_TIME - 1);
    localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_TIME - 1);
    localparam logic [CNT_W-1:0] WIN_LIMIT  = CNT_W'(WINDOW_MIN);

`ifdef WDT_WINDOW_EN
    localparam logic WINDOW_ON = 1'b1;
`else
    localparam logic WINDOW_ON = 1'b0;
`endif

    logic                tick_s1, tick_s2;
    logic [CHANNELS-1:0] kick_s1, kick_s2;
    logic                tick;
    logic [CHANNELS-1:0] kick;

    logic [1:0]          state [CHANNELS];
    logic [CNT_W-1:0]    cnt   [CHANNELS];
    logic [CHANNELS-1:0] reset_q;
    logic [CHANNELS-1:0] sticky_q;
    logic [CHANNELS-1:0] early_q;
    logic                reset_any_q;

    // Two-flop capture of the asynchronous tick and kick inputs; rising edge yields a one-cycle pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tick_s1 <= 1'b0;
            tick_s2 <= 1'b0;
            kick_s1 <= '0;
            kick_s2 <= '0;
        end else begin
            tick_s1 <= CLK_1kHz;
            tick_s2 <= tick_s1;
            kick_s1 <= KICK;
            kick_s2 <= kick_s1;
        end
    end

    assign tick = tick_s1 & ~tick_s2;
    assign kick = kick_s1 & ~kick_s2;

    // Sticky clears are written first so a same-edge set on any channel overrides them.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state[i] <= ST_DISABLED;
                cnt[i]   <= '0;
            end
            reset_q  <= '0;
            sticky_q <= '0;
            early_q  <= '0;
        end else begin
            if (CLR_STICKY) begin
                sticky_q <= '0;
                early_q  <= '0;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (!ENABLE[i]) begin
                    state[i]   <= ST_DISABLED;
                    cnt[i]     <= '0;
                    reset_q[i] <= 1'b0;
                end else begin
                    case (state[i])
                        ST_RUN: begin
                            if (kick[i] && WINDOW_ON && (cnt[i] < WIN_LIMIT)) begin
                                state[i]    <= ST_FIRE;
                                cnt[i]      <= '0;
                                reset_q[i]  <= 1'b1;
                                sticky_q[i] <= 1'b1;
                                early_q[i]  <= 1'b1;
                            end else if (kick[i]) begin
                                cnt[i] <= '0;
                            end else if (tick) begin
                                if (cnt[i] == DELAY_LAST) begin
                                    state[i]    <= ST_FIRE;
                                    cnt[i]      <= '0;
                                    reset_q[i]  <= 1'b1;
                                    sticky_q[i] <= 1'b1;
                                end else begin
                                    cnt[i] <= cnt[i] + CNT_W'(1);
                                end
                            end
                        end
                        ST_FIRE: begin
                            if (tick) begin
                                if (cnt[i] == RESET_LAST) begin
                                    state[i]   <= ST_RUN;
                                    cnt[i]     <= '0;
                                    reset_q[i] <= 1'b0;
                                end else begin
                                    cnt[i] <= cnt[i] + CNT_W'(1);
                                end
                            end
                        end
                        default: begin
                            state[i] <= ST_RUN;
                            cnt[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            reset_any_q <= 1'b0;
        end else begin
            reset_any_q <= |reset_q;
        end
    end

    assign RESET     = reset_q;
    assign RESET_ANY = reset_any_q;
    assign STICKY    = sticky_q;
    assign EARLY     = early_q;

endmodule

// File: doc/wdt_multi.md
# wdt_multi

Multi-channel watchdog timer, parametrised in channel count, counter width and timeout/pulse lengths, with runtime per-channel enable, sticky timeout flags and an optional windowed (early-kick) fault mode. Each channel watches one kick input against a shared 1 kHz timebase and drives its own reset pulse. Sits in the CLOCK subsystem alongside the clock dividers that supply CLK_1kHz, and drives per-subsystem reset requests plus a combined reset.

## Interface
- CHANNELS, 4: number of independent watchdog channels (1..16)
- CNT_W, 16: per-channel tick counter width
- DELAY_TIME, 1000: ticks without a kick before the reset pulse fires (1..2^CNT_W-1)
- RESET_TIME, 50: reset pulse length in ticks (1..2^CNT_W-1)
- WINDOW_MIN, 0: minimum ticks since the last kick for a kick to be legal; only used with WDT_WINDOW_EN

- CLK  in  1  system clock; the only clock
- RST_N  in  1  asynchronous active-low reset
- CLK_1kHz  in  1  timebase; rising edge = one tick; asynchronous, synchronised internally
- KICK  in  CHANNELS  per-channel kick; rising edge = service; asynchronous, synchronised internally
- ENABLE  in  CHANNELS  per-channel run enable, synchronous level
- CLR_STICKY  in  1  synchronous clear of STICKY and EARLY
- RESET  out  CHANNELS  per-channel reset pulse, registered
- RESET_ANY  out  1  registered OR of all RESET bits
- STICKY  out  CHANNELS  set when the channel has fired since the last clear
- EARLY  out  CHANNELS  set when the channel fired on an early kick

## Operation
- Reset (RST_N=0): all outputs 0, all channels DISABLED, counters 0, sync/edge flops 0.
- Sync/edge detection: two flops per asynchronous input. The pulse is stage1 & !stage2, one CLK cycle long.
- Per-channel states:
  - DISABLED: counter 0, RESET 0. If ENABLE=1, go to RUN with counter 0.
  - RUN: tick increments the counter. A kick pulse clears the counter to 0.
    - A tick with counter==DELAY_TIME-1 and no kick: go to FIRE, counter 0, RESET 1, STICKY 1.
  - FIRE: RESET=1 and kicks are ignored. A tick increments the counter.
    - A tick with counter==RESET_TIME-1: go to RUN, counter 0, RESET 0. The channel re-arms automatically.
- ENABLE=0 in any state: go to DISABLED on the next edge. RESET falls on that edge, even mid-pulse. STICKY and EARLY are kept.
- Simultaneous tick and kick in RUN: kick wins and the counter becomes 0. This also applies at counter==DELAY_TIME-1.
- The counter never exceeds DELAY_TIME-1 in RUN or RESET_TIME-1 in FIRE, so there is no wrap-around.
- CLR_STICKY together with a set event on the same edge: set wins.
- Channels are fully independent. They share only the tick pulse and CLR_STICKY.

## Timing
- An input rising edge is first sampled high at CLK edge k. The internal pulse is valid in the following cycle. Counter, state and flags update at edge k+1.
- RESET[i], STICKY[i] and EARLY[i] change at the same edge as the state transition.
- RESET_ANY lags RESET by one cycle. This lag also applies when RESET falls.
- RESET high time is exactly RESET_TIME tick periods, ±1 CLK of jitter from synchronisation.
- Time from the last kick to RESET rising is DELAY_TIME tick periods.
- A KICK or CLK_1kHz high or low phase shorter than 2 CLK cycles may be missed. This is legal and not flagged.
- An ENABLE rise takes effect at the next edge. The counter starts from 0 and the first tick counts.

## Configuration
- Macro WDT_WINDOW_EN.
- Defined: in RUN, a kick pulse with counter < WINDOW_MIN is a fault.
  - The channel goes to FIRE immediately at edge k+1, with counter 0 and RESET 1.
  - STICKY and EARLY are set.
  - If a tick arrives on the same edge, it is not counted toward the old counter.
- Not defined: WINDOW_MIN is ignored, every kick in RUN clears the counter, and EARLY is tied to 0.

## Test plan
Bench parameters: CHANNELS=2, DELAY_TIME=10, RESET_TIME=3, WINDOW_MIN=4, CLK at 50× the tick rate.
- ENABLE=01, no kicks → RESET[0] rises on the 10th tick after enable and falls on the 3rd tick after that. It rises again 10 ticks later. STICKY=01, RESET_ANY follows RESET[0] one cycle later, RESET[1]=0.
- ENABLE=11, KICK[0] every 8 ticks, KICK[1] never → RESET[0]=0 for 200 ticks; RESET[1] pulses every 13 ticks.
- KICK[0] edge aligned with the tick pulse at counter 9 → no fire, counter=0; the next fire comes 10 ticks later.
- Mid-operation events:
  - ENABLE[0] drops during FIRE → RESET[0]=0 at the next edge and STICKY[0] stays 1.
  - RST_N pulsed low mid-count → all outputs 0 immediately, with no CLK edge needed.
- Early kick:
  - With WDT_WINDOW_EN, KICK[0] at counter 2 → RESET[0]=1 and EARLY[0]=1 at k+1.
  - Without it → counter clears to 0, no fire, EARLY=00.
- CLR_STICKY on the same edge as the channel 1 fire → STICKY[1]=1. CLR_STICKY alone 5 cycles later → STICKY=00 and EARLY=00.
